// File: rtl/accumulator_seq_pkg.sv
// Shared constants for the accumulator stage: opcodes, FSM encoding and
// the default datapath width.
package accumulator_seq_pkg;

    localparam int ACC_WIDTH = 8;

    localparam logic [1:0] OP_CLEAR = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_ADD   = 2'b10;
    localparam logic [1:0] OP_SUB   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXEC   = 2'd1,
        ST_RESULT = 2'd2
    } state_t;

endpackage

// File: rtl/adder_basic.sv
// Combinational two's-complement adder/subtractor with signed overflow.
// Subtraction is a + ~b + 1. Overflow is flagged when both addends seen by
// the adder share a sign and the sum's sign differs from it.
module adder_basic #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             subtract,
    output logic [WIDTH-1:0] sum,
    output logic             overflow
);

    logic [WIDTH-1:0] b_eff;

    assign b_eff    = subtract ? ~b : b;
    assign sum      = a + b_eff + {{(WIDTH-1){1'b0}}, subtract};
    assign overflow = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/accumulator_seq.sv
// Sequential accumulator wrapped around adder_basic.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. On the input side the block raises in_ready only in IDLE and
// the producer must hold op/operand stable while in_valid is high until that
// edge. On the output side out_valid stays high, with acc and the flags held
// stable, until the edge where out_ready is also high.
//
// One op is processed at a time: IDLE (accept) -> EXEC (adder + register
// update) -> RESULT (present until taken). The FSM state is exported on
// fsm_state for observability.
module accumulator_seq
    import accumulator_seq_pkg::*;
#(
    parameter int WIDTH    = ACC_WIDTH,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] acc,
    output logic             op_overflow,
    output logic             sticky_overflow,
    output logic [7:0]       op_count,
    output state_t           fsm_state
);

    state_t           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] operand_q, operand_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic             sticky_q, sticky_d;
    logic [7:0]       count_q, count_d;

    logic [WIDTH-1:0] add_sum;
    logic             add_ovf;
    logic [WIDTH-1:0] sat_value;

    adder_basic #(
        .WIDTH (WIDTH)
    ) u_adder (
        .a        (acc_q),
        .b        (operand_q),
        .subtract (op_q == OP_SUB),
        .sum      (add_sum),
        .overflow (add_ovf)
    );

    // Signed overflow always pushes the result past the limit on the side of
    // a's sign, so the clamp value follows the accumulator's sign bit.
    assign sat_value = acc_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                      : {1'b0, {(WIDTH-1){1'b1}}};

    // State and datapath registers; reset discards any op in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_CLEAR;
            operand_q <= '0;
            acc_q     <= '0;
            ovf_q     <= 1'b0;
            sticky_q  <= 1'b0;
            count_q   <= 8'd0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            operand_q <= operand_d;
            acc_q     <= acc_d;
            ovf_q     <= ovf_d;
            sticky_q  <= sticky_d;
            count_q   <= count_d;
        end
    end

    // Next-state and datapath update: capture in IDLE, compute in EXEC,
    // hold in RESULT until the downstream handshake.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        operand_d = operand_q;
        acc_d     = acc_q;
        ovf_d     = ovf_q;
        sticky_d  = sticky_q;
        count_d   = count_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready) begin
                    op_d      = op;
                    operand_d = operand;
                    state_d   = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (op_q)
                    OP_CLEAR: begin
                        acc_d    = '0;
                        ovf_d    = 1'b0;
                        sticky_d = 1'b0;
                    end
                    OP_LOAD: begin
                        acc_d    = operand_q;
                        ovf_d    = 1'b0;
                        sticky_d = 1'b0;
                    end
                    default: begin
                        acc_d    = (SATURATE && add_ovf) ? sat_value : add_sum;
                        ovf_d    = add_ovf;
                        sticky_d = sticky_q | add_ovf;
                    end
                endcase
                state_d = ST_RESULT;
            end
            ST_RESULT: begin
                if (out_ready) begin
                    count_d = count_q + 8'd1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // in_ready is gated by rst so nothing is accepted while reset is held.
    assign in_ready        = (state_q == ST_IDLE) && !rst;
    assign out_valid       = (state_q == ST_RESULT);
    assign acc             = acc_q;
    assign op_overflow     = ovf_q;
    assign sticky_overflow = sticky_q;
    assign op_count        = count_q;
    assign fsm_state       = state_q;

endmodule

// File: tb/tb_accumulator_seq.sv
// Bench for accumulator_seq: a wrapping and a saturating instance run in
// lockstep on the same stimulus; expected results are queued at accept time
// and popped when the result is presented.
module tb_accumulator_seq;
    import accumulator_seq_pkg::*;

    localparam int W     = 8;
    localparam int EXP_W = 2 * (W + 2);

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [1:0]   op;
    logic [W-1:0] operand;
    logic         out_ready;

    logic         in_ready,    in_ready_s;
    logic         out_valid,   out_valid_s;
    logic [W-1:0] acc,         acc_s;
    logic         op_overflow, op_overflow_s;
    logic         sticky,      sticky_s;
    logic [7:0]   op_count,    op_count_s;
    state_t       fsm_state,   fsm_state_s;

    logic [EXP_W-1:0] exp_q[$];
    int errors = 0;
    int checks = 0;

    logic [W-1:0] m_acc_w, m_acc_s;
    logic         m_sticky_w, m_sticky_s;
    logic [7:0]   m_count;

    accumulator_seq #(.WIDTH(W), .SATURATE(1'b0)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .operand(operand), .out_valid(out_valid), .out_ready(out_ready),
        .acc(acc), .op_overflow(op_overflow), .sticky_overflow(sticky),
        .op_count(op_count), .fsm_state(fsm_state)
    );

    accumulator_seq #(.WIDTH(W), .SATURATE(1'b1)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
        .op(op), .operand(operand), .out_valid(out_valid_s), .out_ready(out_ready),
        .acc(acc_s), .op_overflow(op_overflow_s), .sticky_overflow(sticky_s),
        .op_count(op_count_s), .fsm_state(fsm_state_s)
    );

    // clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: exact integer arithmetic, then range test for overflow.
    function automatic logic [W:0] model_step(input logic [1:0] o, input logic [W-1:0] d,
                                              input logic [W-1:0] a, input bit sat);
        int av, bv, r;
        logic ov;
        logic [W-1:0] res;
        if (o == OP_CLEAR) return {1'b0, {W{1'b0}}};
        if (o == OP_LOAD)  return {1'b0, d};
        av = $signed(a);
        bv = $signed(d);
        r  = (o == OP_ADD) ? av + bv : av - bv;
        ov = (r > 127) || (r < -128);
        if (ov && sat) res = (r > 127) ? 8'h7F : 8'h80;
        else           res = r[W-1:0];
        return {ov, res};
    endfunction

    task automatic push_expected(input logic [1:0] o, input logic [W-1:0] d);
        logic [W:0] rw, rs;
        rw = model_step(o, d, m_acc_w, 1'b0);
        rs = model_step(o, d, m_acc_s, 1'b1);
        m_acc_w = rw[W-1:0];
        m_acc_s = rs[W-1:0];
        if (o == OP_CLEAR || o == OP_LOAD) begin
            m_sticky_w = 1'b0;
            m_sticky_s = 1'b0;
        end else begin
            m_sticky_w = m_sticky_w | rw[W];
            m_sticky_s = m_sticky_s | rs[W];
        end
        exp_q.push_back({m_acc_w, rw[W], m_sticky_w, m_acc_s, rs[W], m_sticky_s});
    endtask

    task automatic check_result(input logic [EXP_W-1:0] e);
        check("acc_wrap",    acc,           e[EXP_W-1 -: W]);
        check("ovf_wrap",    op_overflow,   e[W+3]);
        check("sticky_wrap", sticky,        e[W+2]);
        check("acc_sat",     acc_s,         e[W+1:2]);
        check("ovf_sat",     op_overflow_s, e[1]);
        check("sticky_sat",  sticky_s,      e[0]);
        check("count_hold",  {op_count, op_count_s}, {m_count, m_count});
        check("in_ready_busy", {in_ready, in_ready_s}, 2'b00);
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!(in_ready && in_ready_s) && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_wait", in_ready && in_ready_s, 1'b1);
    endtask

    // Called at a negedge; returns at a negedge after the output handshake.
    task automatic send_op(input logic [1:0] o, input logic [W-1:0] d, input int stall);
        logic [EXP_W-1:0] e;
        wait_ready();
        op       = o;
        operand  = d;
        in_valid = 1'b1;
        push_expected(o, d);
        @(negedge clk);
        in_valid = 1'b0;
        op       = 2'($urandom_range(0, 3));
        operand  = 8'($urandom_range(0, 255));
        check("exec_state", {fsm_state, fsm_state_s}, {ST_EXEC, ST_EXEC});
        check("exec_out_valid", {out_valid, out_valid_s}, 2'b00);
        @(negedge clk);
        check("result_out_valid", {out_valid, out_valid_s}, 2'b11);
        e = exp_q.pop_front();
        check_result(e);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("stall_out_valid", {out_valid, out_valid_s}, 2'b11);
            check_result(e);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        m_count = m_count + 8'd1;
        check("done_out_valid", {out_valid, out_valid_s}, 2'b00);
        check("done_count", {op_count, op_count_s}, {m_count, m_count});
        check("done_in_ready", {in_ready, in_ready_s}, 2'b11);
    endtask

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        op         = OP_CLEAR;
        operand    = '0;
        out_ready  = 1'b0;
        m_acc_w    = '0;
        m_acc_s    = '0;
        m_sticky_w = 1'b0;
        m_sticky_s = 1'b0;
        m_count    = 8'd0;

        // reset state
        #1;
        check("rst_in_ready",  {in_ready, in_ready_s}, 2'b00);
        check("rst_out_valid", {out_valid, out_valid_s}, 2'b00);
        check("rst_acc",       {acc, acc_s}, 16'h0000);
        check("rst_flags",     {op_overflow, sticky, op_overflow_s, sticky_s}, 4'b0000);
        check("rst_count",     {op_count, op_count_s}, 16'h0000);
        check("rst_state",     {fsm_state, fsm_state_s}, {ST_IDLE, ST_IDLE});
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("release_in_ready", {in_ready, in_ready_s}, 2'b11);
        @(negedge clk);

        // basic load/add
        send_op(OP_LOAD, 8'h17, 0);
        send_op(OP_ADD,  8'h3C, 0);
        check("basic_acc",   acc, 8'h53);
        check("basic_count", op_count, 8'd2);

        // positive overflow, wrap vs saturate, sticky persists
        send_op(OP_LOAD, 8'h64, 0);
        send_op(OP_ADD,  8'h1C, 0);
        check("ovf_acc_wrap", acc,   8'h80);
        check("ovf_acc_sat",  acc_s, 8'h7F);
        send_op(OP_ADD,  8'h00, 1);
        check("sticky_kept", {op_overflow, sticky}, 2'b01);

        // subtract boundary and clear
        send_op(OP_LOAD, 8'h64, 0);
        send_op(OP_SUB,  8'hE5, 0);
        check("sub_edge_acc", acc, 8'h7F);
        send_op(OP_LOAD, 8'h64, 0);
        send_op(OP_SUB,  8'hE4, 0);
        check("sub_ovf_acc", {acc, acc_s}, 16'h807F);
        send_op(OP_CLEAR, 8'h5A, 0);
        check("clear_sticky", {sticky, sticky_s}, 2'b00);

        // negative overflow with backpressure
        send_op(OP_LOAD, 8'h90, 0);
        send_op(OP_ADD,  8'h90, 5);
        send_op(OP_SUB,  8'h7F, 3);

        // random ops with random stalls
        for (int i = 0; i < 24; i++) begin
            send_op(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)),
                    $urandom_range(0, 2));
        end

        // async reset during EXEC of ADD 0x01
        send_op(OP_LOAD, 8'h33, 0);
        wait_ready();
        op       = OP_ADD;
        operand  = 8'h01;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("pre_rst_state", fsm_state, ST_EXEC);
        rst = 1'b1;
        #1;
        check("async_acc",       {acc, acc_s}, 16'h0000);
        check("async_flags",     {op_overflow, sticky, op_overflow_s, sticky_s}, 4'b0000);
        check("async_out_valid", {out_valid, out_valid_s}, 2'b00);
        check("async_in_ready",  {in_ready, in_ready_s}, 2'b00);
        check("async_count",     {op_count, op_count_s}, 16'h0000);
        m_acc_w    = '0;
        m_acc_s    = '0;
        m_sticky_w = 1'b0;
        m_sticky_s = 1'b0;
        m_count    = 8'd0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", {in_ready, in_ready_s}, 2'b11);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("no_stale_result", {out_valid, out_valid_s}, 2'b00);
        end

        // counter wrap
        for (int i = 0; i < 257; i++) begin
            send_op(OP_LOAD, 8'h01, 0);
        end
        check("count_wrap", op_count, 8'h01);
        check("queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
